ram_master: RTL and testbench
=============================

// Module: ram_master
// PURPOSE
//  Initiator for the single-port synchronous ram (data/addr/wr/clk/out).
//  Takes burst read/write requests from a client over valid/ready and
//  drives the ram one word per cycle; read data returns with a valid strobe.
//  Sits between the ram and any client (CPU load/store unit, DMA, test
//  sequencer); the only block allowed to drive ram.addr/data/wr.
// PARAMETERS
//  AW         32  ram address width (bits)
//  DW         32  ram data width (bits)
//  LW          8  burst length field width; beats = req_len+1 (1..2^LW)
//  RD_LATENCY  1  cycles from ram.addr sampled (wr=0) to ram.out valid
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   client request present
//  req_ready    out  1   master idle, request accepted when valid&ready
//  req_wr       in   1   1=write burst, 0=read burst
//  req_addr     in   AW  start word address
//  req_len      in   LW  beats-1
//  wdata        in   DW  write beat data
//  wdata_valid  in   1   write beat present
//  wdata_ready  out  1   master consumes beat when valid&ready
//  rdata        out  DW  read beat data (= ram_out)
//  rdata_valid  out  1   rdata valid this cycle; no backpressure
//  done         out  1   one-cycle pulse: burst complete
//  busy         out  1   state != IDLE
//  ram_addr     out  AW  to ram.addr (registered)
//  ram_data     out  DW  to ram.data (registered)
//  ram_wr       out  1   to ram.wr (registered)
//  ram_out      in   DW  from ram.out
// BEHAVIOUR
//  Reset: state=IDLE; ram_addr, ram_data, ram_wr, rdata_valid, done, busy,
//   wdata_ready = 0; req_ready=1; beat counter and read pipe cleared.
//  FSM: IDLE -> WRITE (req_valid&req_ready&req_wr), IDLE -> RD_ISSUE (..&!req_wr);
//   WRITE -> IDLE after last beat registered; RD_ISSUE -> RD_DRAIN after last
//   addr issued; RD_DRAIN -> IDLE when read pipe empty.
//  req_ready = (state==IDLE); req_* sampled only on accept edge; req_valid
//   while busy ignored.
//  WRITE: wdata_ready=1; each valid beat -> next edge ram_wr=1, ram_data=wdata,
//   ram_addr=cur; cur+=1. Beat-less cycle -> ram_wr=0 (bubble, no addr step).
//  RD_ISSUE: one addr per cycle, ram_wr=0, no bubbles. Valid bit shifts
//   through RD_LATENCY+1 stage pipe; rdata_valid = pipe tail, rdata = ram_out.
//   Latency: accept at edge N -> first rdata_valid in cycle after edge
//   N+1+RD_LATENCY; beats contiguous, in address order.
//  done: pulses in first IDLE cycle after burst; req_ready also 1 that
//   cycle, so back-to-back requests lose no cycle.
//  Address: cur wraps mod 2^AW (0xFFFF_FFFF+1 -> 0), burst continues.
//  ram_wr is 0 in every state except a WRITE beat cycle; ram_addr holds
//   last value while idle.
//  Reset mid-burst: immediate abort, no done, in-flight reads dropped
//   (rdata_valid=0), partially written ram contents left as-is.
// STRUCTURE
//  ram_master_defs.vh: state encodings (IDLE/WRITE/RD_ISSUE/RD_DRAIN),
//   default AW/DW/LW widths - shared with client blocks and benches.
//  Sub-module ram_rd_pipe: RD_LATENCY+1 deep valid shift register, async
//   reset, outputs tail and empty. Rest (FSM, counter, regs) in ram_master.
// TESTING (bench instantiates ram_master + ram, clk period 100)
//  1 Single writes 0x01@1, 0x02@2, 0x00@0 (len=0) -> ram_wr one cycle each,
//    done after each; reads @0,@1,@2 -> rdata 0x00,0x01,0x02.
//  2 Write burst addr=0x10 len=3 data 0xA..0xD, then read burst same ->
//    4 contiguous rdata_valid 0xA,0xB,0xC,0xD, one done per burst.
//  3 Write burst len=3 with wdata_valid gapped 1-on/1-off -> ram_wr bubbles,
//    addresses 0x10..0x13 each written once, done after 4th beat.
//  4 Read burst addr=0xFFFF_FFFE len=3 -> ram_addr FFFFFFFE,FFFFFFFF,0,1.
//  5 req_valid held high while busy -> ignored; second request accepted in
//    done cycle with zero idle gap.
//  6 rst during read burst beat 2 -> outputs to reset values within same
//    cycle, no done, no further rdata_valid; next request works normally.

Source files
------------

// File: rtl/ram_master_pkg.sv
// ram_master_pkg: state encoding and default widths shared by ram_master, its clients and benches
package ram_master_pkg;
    localparam int AW_DEF         = 32;
    localparam int DW_DEF         = 32;
    localparam int LW_DEF         = 8;
    localparam int RD_LATENCY_DEF = 1;
    typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_DRAIN} state_e;
endpackage

// File: rtl/ram_master_rd_pipe.sv
// ram_master_rd_pipe: valid-bit shift register tracking reads in flight through the ram
//   clk, rst   clock, async active-high reset
//   in_valid   a read address is being registered this cycle
//   tail       ram_out carries valid read data this cycle
//   empty      no read in flight behind the tail stage
module ram_master_rd_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic tail,
    output logic empty
);
    logic [DEPTH-1:0] v_q, v_d;
    always_comb v_d = (v_q << 1) | DEPTH'(in_valid);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_q <= '0;
        else     v_q <= v_d;
    end
    assign tail = v_q[DEPTH-1];
    // The tail stage is excluded so the FSM can leave drain while the final beat is on rdata.
    assign empty = ~|(v_q << 1);
endmodule

// File: rtl/ram_master.sv
// ram_master: burst read/write initiator driving a single-port synchronous ram
//   clk, rst                           clock, async active-high reset
//   req_valid/ready, req_wr/addr/len   burst request handshake, beats = req_len+1
//   wdata, wdata_valid/ready           write beat stream
//   rdata, rdata_valid                 read beat stream, no backpressure
//   done, busy                         burst-complete pulse, non-idle status
//   ram_addr, ram_data, ram_wr         registered ram controls
//   ram_out                            ram read data
module ram_master
    import ram_master_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int LW         = LW_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic [DW-1:0] wdata,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wr,
    input  logic [DW-1:0] ram_out
);
    state_e        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d, ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_data_q, ram_data_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          ram_wr_q, ram_wr_d, done_q, done_d;
    logic          issue, pipe_empty;

    // The valid bit enters the pipe together with ram_addr_q, so its tail lines up with ram_out.
    ram_master_rd_pipe #(.DEPTH(RD_LATENCY + 1)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (issue),
        .tail     (rdata_valid),
        .empty    (pipe_empty)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wr_d   = 1'b0;
        done_d     = 1'b0;
        issue      = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = req_wr ? WRITE : RD_ISSUE;
                cur_d   = req_addr;
                cnt_d   = req_len;
            end
            WRITE: if (wdata_valid) begin
                ram_wr_d   = 1'b1;
                ram_data_d = wdata;
                ram_addr_d = cur_q;
                cur_d      = cur_q + 1'b1;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            RD_ISSUE: begin
                issue      = 1'b1;
                ram_addr_d = cur_q;
                cur_d      = cur_q + 1'b1;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = RD_DRAIN;
            end
            RD_DRAIN: if (pipe_empty) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wr_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wr_q   <= ram_wr_d;
            done_q     <= done_d;
        end
    end

    assign req_ready   = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign wdata_ready = state_q == WRITE;
    assign done        = done_q;
    assign rdata       = ram_out;
    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign ram_wr      = ram_wr_q;
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: randomized self-checking bench for ram_master with a behavioural ram and memory model
module tb_ram_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_wr, wdata_valid;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic [DW-1:0] wdata;
    logic          req_ready, wdata_ready, rdata_valid, done, busy, ram_wr;
    logic [DW-1:0] rdata, ram_data, ram_out;
    logic [AW-1:0] ram_addr;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [DW-1:0] ram_mem [256] = '{default: '0};
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] wbuf [16];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q [$];
    logic [DW-1:0] rd_q [$];
    int            rd_cyc_q [$];
    logic [AW-1:0] addr_at [int];
    int   done_cnt, done_cyc, acc_cyc;
    logic ready_at_done;

    ram_master dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .busy        (busy),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_wr      (ram_wr),
        .ram_out     (ram_out)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // single-port synchronous ram, one cycle read latency, read-before-write
    always @(posedge clk) begin
        ram_out <= ram_mem[ram_addr[7:0]];
        if (ram_wr) ram_mem[ram_addr[7:0]] <= ram_data;
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            addr_at[cyc] = ram_addr;
            if (ram_wr) begin
                wr_addr_q.push_back(ram_addr);
                wr_data_q.push_back(ram_data);
                wr_cyc_q.push_back(cyc);
            end
            if (rdata_valid) begin
                rd_q.push_back(rdata);
                rd_cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                ready_at_done = req_ready;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        rd_q.delete();
        rd_cyc_q.delete();
        addr_at.delete();
        done_cnt = 0;
        done_cyc = -1;
        ready_at_done = 1'b0;
    endtask

    // mode 0: beat every cycle, 1: alternate on/off, 2: random gaps; hold keeps req_valid high with a follow-on read
    task automatic write_burst(input logic [AW-1:0] a, input int l, input int mode, input bit hold,
                               input logic [AW-1:0] ha, input int hl);
        int  i, t;
        bit  ph, en;
        clear_logs();
        req_valid = 1'b1;
        req_wr = 1'b1;
        req_addr = a;
        req_len = LW'(l);
        acc_cyc = cyc + 1;
        tick();
        if (hold) begin
            req_wr = 1'b0;
            req_addr = ha;
            req_len = LW'(hl);
        end else req_valid = 1'b0;
        i = 0;
        t = 0;
        ph = 1'b0;
        while (i <= l && t < 200) begin
            en = (mode == 0) || (mode == 1 && !ph) || (mode == 2 && $urandom_range(0, 1) == 1);
            ph = !ph;
            wdata_valid = en && wdata_ready;
            wdata = wbuf[i];
            if (wdata_valid) i++;
            tick();
            t++;
        end
        wdata_valid = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 20) begin
            tick();
            t++;
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int l);
        int t;
        clear_logs();
        req_valid = 1'b1;
        req_wr = 1'b0;
        req_addr = a;
        req_len = LW'(l);
        acc_cyc = cyc + 1;
        tick();
        req_valid = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < l + 50) begin
            tick();
            t++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_addr = '0;
        req_len = '0;
        wdata = '0;
        wdata_valid = 1'b0;
        repeat (2) tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (wdata_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wdata_ready: got %b want 0", wdata_ready); end
        n_checks++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_valid: got %b want 0", rdata_valid); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (ram_wr !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wr: got %b want 0", ram_wr); end
        n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        n_checks++; if (ram_data !== '0) begin n_fail++; $display("FAIL reset_ram_data: got %h want 0", ram_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        logic [AW-1:0] a;
        for (int k = 0; k < 3; k++) begin
            a = (k == 0) ? 32'd1 : (k == 1) ? 32'd2 : 32'd0;
            wbuf[0] = a;
            write_burst(a, 0, 0, 1'b0, '0, 0);
            ref_mem[a] = a;
            n_checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== a || wr_data_q[0] !== a) begin
                n_fail++; $display("FAIL single_write@%0h: %0d ram_wr cycles, first addr %h data %h, want 1 cycle addr %h data %h",
                                   a, wr_addr_q.size(), wr_addr_q.size() ? wr_addr_q[0] : '0, wr_data_q.size() ? wr_data_q[0] : '0, a, a); end
            n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_write_done@%0h: got %0d pulses want 1", a, done_cnt); end
        end
        for (int k = 0; k < 3; k++) begin
            read_burst(AW'(k), 0);
            n_checks++; if (rd_q.size() != 1 || rd_q[0] !== ref_rd(AW'(k))) begin
                n_fail++; $display("FAIL single_read@%0d: %0d beats first %h, want 1 beat %h",
                                   k, rd_q.size(), rd_q.size() ? rd_q[0] : '0, ref_rd(AW'(k))); end
        end
    endtask

    task automatic test_burst;
        for (int i = 0; i < 4; i++) wbuf[i] = DW'(32'hA + i);
        write_burst(32'h10, 3, 0, 1'b0, '0, 0);
        for (int i = 0; i < 4; i++) ref_mem[32'h10 + i] = wbuf[i];
        n_checks++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL burst_write_count: got %0d want 4", wr_addr_q.size()); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL burst_write_done: got %0d want 1", done_cnt); end
        read_burst(32'h10, 3);
        n_checks++; if (rd_q.size() != 4) begin n_fail++; $display("FAIL burst_read_count: got %0d want 4", rd_q.size()); end
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            n_checks++; if (rd_q[i] !== DW'(32'hA + i)) begin n_fail++; $display("FAIL burst_read_beat%0d: got %h want %h", i, rd_q[i], 32'hA + i); end
        end
        n_checks++; if (rd_q.size() == 0 || rd_cyc_q[0] != acc_cyc + 1 + RD_LAT) begin
            n_fail++; $display("FAIL burst_read_latency: first beat cycle %0d want %0d", rd_q.size() ? rd_cyc_q[0] : -1, acc_cyc + 1 + RD_LAT); end
        n_checks++; if (rd_q.size() == 0 || rd_cyc_q[rd_cyc_q.size()-1] - rd_cyc_q[0] != rd_q.size() - 1) begin
            n_fail++; $display("FAIL burst_read_contiguous: beats spread over %0d cycles want %0d", rd_q.size() ? rd_cyc_q[rd_cyc_q.size()-1] - rd_cyc_q[0] + 1 : 0, rd_q.size()); end
        n_checks++; if (done_cnt != 1 || rd_q.size() == 0 || done_cyc <= rd_cyc_q[rd_cyc_q.size()-1]) begin
            n_fail++; $display("FAIL burst_read_done: %0d pulses at cycle %0d, want 1 after last beat", done_cnt, done_cyc); end
    endtask

    task automatic test_gapped;
        for (int i = 0; i < 4; i++) wbuf[i] = DW'(32'h21 + i);
        write_burst(32'h10, 3, 1, 1'b0, '0, 0);
        for (int i = 0; i < 4; i++) ref_mem[32'h10 + i] = wbuf[i];
        n_checks++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL gapped_count: got %0d writes want 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            n_checks++; if (wr_addr_q[i] !== AW'(32'h10 + i) || wr_data_q[i] !== wbuf[i]) begin
                n_fail++; $display("FAIL gapped_beat%0d: addr %h data %h want addr %h data %h", i, wr_addr_q[i], wr_data_q[i], 32'h10 + i, wbuf[i]); end
        end
        n_checks++; if (wr_cyc_q.size() != 4 || wr_cyc_q[3] - wr_cyc_q[0] <= 3) begin
            n_fail++; $display("FAIL gapped_bubbles: writes not spread out, span %0d", wr_cyc_q.size() == 4 ? wr_cyc_q[3] - wr_cyc_q[0] : -1); end
        n_checks++; if (done_cnt != 1 || wr_cyc_q.size() != 4 || done_cyc != wr_cyc_q[3]) begin
            n_fail++; $display("FAIL gapped_done: %0d pulses at cycle %0d, want 1 at last beat cycle", done_cnt, done_cyc); end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] a, e;
        int c;
        a = 32'hFFFF_FFFE;
        read_burst(a, 3);
        for (int i = 0; i < 4; i++) begin
            e = a + AW'(i);
            c = acc_cyc + 1 + i;
            n_checks++; if (!addr_at.exists(c) || addr_at[c] !== e) begin
                n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr_at.exists(c) ? addr_at[c] : '0, e); end
        end
        n_checks++; if (rd_q.size() != 4 || rd_q[2] !== ref_rd(32'h0) || rd_q[3] !== ref_rd(32'h1)) begin
            n_fail++; $display("FAIL wrap_data: %0d beats, beats 2/3 %h %h want %h %h", rd_q.size(),
                               rd_q.size() > 2 ? rd_q[2] : '0, rd_q.size() > 3 ? rd_q[3] : '0, ref_rd(32'h0), ref_rd(32'h1)); end
    endtask

    task automatic test_back_to_back;
        int dc, t;
        wbuf[0] = 32'hB0B0_0001;
        wbuf[1] = 32'hB0B0_0002;
        write_burst(32'h40, 1, 0, 1'b1, 32'h10, 3);
        ref_mem[32'h40] = wbuf[0];
        ref_mem[32'h41] = wbuf[1];
        dc = done_cyc;
        n_checks++; if (wr_addr_q.size() != 2 || rd_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_ignored: %0d writes %0d read beats during write, want 2 and 0", wr_addr_q.size(), rd_q.size()); end
        n_checks++; if (done_cnt != 1 || ready_at_done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done_ready: %0d pulses req_ready %b, want 1 pulse with ready 1", done_cnt, ready_at_done); end
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap: busy %b want 1 right after done", busy); end
        req_valid = 1'b0;
        t = 0;
        while (done_cnt < 2 && t < 60) begin
            tick();
            t++;
        end
        n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_second_done: got %0d pulses want 2", done_cnt); end
        n_checks++; if (rd_q.size() != 4 || rd_cyc_q[0] != dc + 2 + RD_LAT) begin
            n_fail++; $display("FAIL b2b_read_timing: %0d beats first at %0d, want 4 first at %0d", rd_q.size(), rd_q.size() ? rd_cyc_q[0] : -1, dc + 2 + RD_LAT); end
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            n_checks++; if (rd_q[i] !== ref_rd(32'h10 + i)) begin n_fail++; $display("FAIL b2b_read_beat%0d: got %h want %h", i, rd_q[i], ref_rd(32'h10 + i)); end
        end
    endtask

    task automatic test_reset_mid;
        int t;
        clear_logs();
        req_valid = 1'b1;
        req_wr = 1'b0;
        req_addr = 32'h10;
        req_len = LW'(7);
        tick();
        req_valid = 1'b0;
        t = 0;
        while (rd_q.size() < 2 && t < 30) begin
            tick();
            t++;
        end
        n_checks++; if (rd_q.size() != 2) begin n_fail++; $display("FAIL rstmid_reach_beat2: got %0d beats want 2", rd_q.size()); end
        #10 rst = 1'b1;
        #1;
        n_checks++; if (rdata_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || ram_wr !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: rdata_valid %b busy %b req_ready %b done %b ram_wr %b want 0 0 1 0 0",
                               rdata_valid, busy, req_ready, done, ram_wr); end
        tick();
        rst = 1'b0;
        clear_logs();
        repeat (12) tick();
        n_checks++; if (rd_q.size() != 0 || done_cnt != 0) begin
            n_fail++; $display("FAIL rstmid_quiet: %0d beats %0d done after reset, want 0 0", rd_q.size(), done_cnt); end
        read_burst(32'h10, 3);
        n_checks++; if (rd_q.size() != 4 || done_cnt != 1 || rd_q[0] !== ref_rd(32'h10) || rd_q[3] !== ref_rd(32'h13)) begin
            n_fail++; $display("FAIL rstmid_recover: %0d beats %0d done, want 4 beats from %h to %h", rd_q.size(), done_cnt, ref_rd(32'h10), ref_rd(32'h13)); end
    endtask

    task automatic test_random;
        logic [AW-1:0] a;
        int l;
        for (int n = 0; n < 24; n++) begin
            a = 32'h20 + AW'($urandom_range(0, 175));
            l = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= l; i++) wbuf[i] = $urandom;
                write_burst(a, l, $urandom_range(0, 2), 1'b0, '0, 0);
                for (int i = 0; i <= l; i++) ref_mem[a + AW'(i)] = wbuf[i];
                n_checks++; if (wr_addr_q.size() != l + 1 || done_cnt != 1) begin
                    n_fail++; $display("FAIL rand_write%0d: %0d writes %0d done want %0d and 1", n, wr_addr_q.size(), done_cnt, l + 1); end
                for (int i = 0; i <= l && i < wr_addr_q.size(); i++) begin
                    n_checks++; if (wr_addr_q[i] !== a + AW'(i) || wr_data_q[i] !== wbuf[i]) begin
                        n_fail++; $display("FAIL rand_write%0d_beat%0d: addr %h data %h want %h %h", n, i, wr_addr_q[i], wr_data_q[i], a + AW'(i), wbuf[i]); end
                end
            end else begin
                read_burst(a, l);
                n_checks++; if (rd_q.size() != l + 1 || done_cnt != 1) begin
                    n_fail++; $display("FAIL rand_read%0d: %0d beats %0d done want %0d and 1", n, rd_q.size(), done_cnt, l + 1); end
                for (int i = 0; i <= l && i < rd_q.size(); i++) begin
                    n_checks++; if (rd_q[i] !== ref_rd(a + AW'(i))) begin
                        n_fail++; $display("FAIL rand_read%0d_beat%0d: got %h want %h", n, i, rd_q[i], ref_rd(a + AW'(i))); end
                end
            end
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_single();
        test_burst();
        test_gapped();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
